// File: rtl/fft_dma_pkg.sv
// Shared definitions for the FFT DMA front/back end (clocking_in, clocking_out,
// butterfly stages): default frame geometry and the complex sample types.
package fft_dma_pkg;

   localparam int FFT_SIZE_DEF     = 8;
   localparam int FFT_SIZE_LOG_DEF = 3;
   localparam int WIDTH_DEF        = 18;
   localparam int DECIMAL_DEF      = 10;

   typedef logic signed [WIDTH_DEF-1:0] sample_t;

   typedef struct packed {
      sample_t re;
      sample_t im;
   } cplx_t;

endpackage

// File: rtl/out_frame_buf.sv
// One frame slot of the output ping-pong buffer: whole-frame parallel load
// from the last butterfly stage, single-sample indexed read for streaming.
module out_frame_buf
   import fft_dma_pkg::*;
#(
   parameter int FFT_SIZE     = FFT_SIZE_DEF,
   parameter int FFT_SIZE_LOG = FFT_SIZE_LOG_DEF,
   parameter int WIDTH        = WIDTH_DEF
)(
   input  logic                      clk,
   input  logic                      load,
   input  logic [FFT_SIZE*WIDTH-1:0] data_in_R,
   input  logic [FFT_SIZE*WIDTH-1:0] data_in_I,
   input  logic [FFT_SIZE_LOG-1:0]   rd_idx,
   output logic [WIDTH-1:0]          rd_R,
   output logic [WIDTH-1:0]          rd_I
);

   logic [FFT_SIZE*WIDTH-1:0] mem_R;
   logic [FFT_SIZE*WIDTH-1:0] mem_I;

   // Frame storage needs no reset: the control logic never reads an unloaded slot.
   always_ff @(posedge clk) begin
      if (load) begin
         mem_R <= data_in_R;
         mem_I <= data_in_I;
      end
   end

   assign rd_R = mem_R[rd_idx*WIDTH +: WIDTH];
   assign rd_I = mem_I[rd_idx*WIDTH +: WIDTH];

endmodule

// File: rtl/clocking_out.sv
// Output serializer: captures parallel FFT frames into a two-slot ping-pong
// buffer and streams them sample by sample over an AXI-stream style handshake.
module clocking_out
   import fft_dma_pkg::*;
#(
   parameter int FFT_SIZE     = FFT_SIZE_DEF,
   parameter int FFT_SIZE_LOG = FFT_SIZE_LOG_DEF,
   parameter int WIDTH        = WIDTH_DEF
)(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   output logic                      ready,
   input  logic [FFT_SIZE*WIDTH-1:0] data_in_R,
   input  logic [FFT_SIZE*WIDTH-1:0] data_in_I,
   output logic                      dma_tvalid,
   input  logic                      dma_tready,
   output logic                      dma_tlast,
   output logic [WIDTH-1:0]          data_out_R,
   output logic [WIDTH-1:0]          data_out_I,
   output logic                      overflow
);

   localparam logic [FFT_SIZE_LOG-1:0] LAST_IDX = FFT_SIZE_LOG'(FFT_SIZE - 1);

   logic [1:0]              full;
   logic [1:0]              full_next;
   logic                    wr_sel;
   logic                    rd_sel;
   logic                    rd_sel_next;
   logic [FFT_SIZE_LOG-1:0] idx;
   logic [FFT_SIZE_LOG-1:0] idx_next;
   logic                    tvalid_next;
   logic                    tlast_next;
   logic                    capture;
   logic                    beat;
   logic [WIDTH-1:0]        slot_R [2];
   logic [WIDTH-1:0]        slot_I [2];
   logic [WIDTH-1:0]        data_next_R;
   logic [WIDTH-1:0]        data_next_I;

   // ready deliberately ignores a slot that frees this cycle (no look-ahead)
   assign ready   = ~(full[0] & full[1]);
   assign capture = start & ready;
   assign beat    = dma_tvalid & dma_tready;

   // Both slots read at the next sample index; the output register picks one
   for (genvar s = 0; s < 2; s++) begin : g_slot
      out_frame_buf #(
         .FFT_SIZE     (FFT_SIZE),
         .FFT_SIZE_LOG (FFT_SIZE_LOG),
         .WIDTH        (WIDTH)
      ) u_buf (
         .clk       (clk),
         .load      (capture && (wr_sel == 1'(s))),
         .data_in_R (data_in_R),
         .data_in_I (data_in_I),
         .rd_idx    (idx_next),
         .rd_R      (slot_R[s]),
         .rd_I      (slot_I[s])
      );
   end

   // Next slot flags, read pointer and sample index; outputs are precomputed so
   // the first sample of a waiting frame follows the last beat with no bubble.
   always_comb begin
      full_next   = full;
      rd_sel_next = rd_sel;
      idx_next    = idx;
      if (capture) begin
         full_next[wr_sel] = 1'b1;
      end
      if (beat) begin
         if (idx == LAST_IDX) begin
            idx_next          = '0;
            full_next[rd_sel] = 1'b0;
            rd_sel_next       = ~rd_sel;
         end else begin
            idx_next = idx + FFT_SIZE_LOG'(1);
         end
      end
      tvalid_next = full[rd_sel_next];
      tlast_next  = tvalid_next & (idx_next == LAST_IDX);
      data_next_R = slot_R[rd_sel_next];
      data_next_I = slot_I[rd_sel_next];
   end

   // Control and output registers; reset discards any frame being streamed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full       <= '0;
         wr_sel     <= 1'b0;
         rd_sel     <= 1'b0;
         idx        <= '0;
         dma_tvalid <= 1'b0;
         dma_tlast  <= 1'b0;
         data_out_R <= '0;
         data_out_I <= '0;
         overflow   <= 1'b0;
      end else begin
         full       <= full_next;
         rd_sel     <= rd_sel_next;
         idx        <= idx_next;
         dma_tvalid <= tvalid_next;
         dma_tlast  <= tlast_next;
         data_out_R <= data_next_R;
         data_out_I <= data_next_I;
         if (capture) begin
            wr_sel <= ~wr_sel;
         end
         if (start && !ready) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_clocking_out.sv
// Self-checking bench for clocking_out: a frame-queue model predicts every
// output each cycle, and directed checks pin latency, counts and boundaries.
module tb_clocking_out;

   localparam int N = 8;
   localparam int W = 18;

   logic         clk        = 1'b0;
   logic         rst_n      = 1'b0;
   logic         start      = 1'b0;
   logic         dma_tready = 1'b0;
   logic [N*W-1:0] data_in_R = '0;
   logic [N*W-1:0] data_in_I = '0;
   logic         ready;
   logic         dma_tvalid;
   logic         dma_tlast;
   logic         overflow;
   logic [W-1:0] data_out_R;
   logic [W-1:0] data_out_I;

   typedef struct {
      int r;
      int i;
      bit last;
      int cyc;
   } exp_t;

   exp_t q[$];
   int   edge_cnt = 0;
   bit   m_ovf    = 1'b0;
   int   stim_r[N];
   int   stim_i[N];
   int   n_cmp = 0;
   int   n_fail = 0;
   int   beat_cnt = 0;
   int   tlast_cnt = 0;
   int   tlast_at = 0;
   int   first_beat = 0;
   int   last_beat = 0;

   always #5 clk = ~clk;

   clocking_out #(
      .FFT_SIZE     (N),
      .FFT_SIZE_LOG (3),
      .WIDTH        (W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .ready      (ready),
      .data_in_R  (data_in_R),
      .data_in_I  (data_in_I),
      .dma_tvalid (dma_tvalid),
      .dma_tready (dma_tready),
      .dma_tlast  (dma_tlast),
      .data_out_R (data_out_R),
      .data_out_I (data_out_I),
      .overflow   (overflow)
   );

   task automatic checkOutput(input string name, input int act, input int expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
      end
   endtask

   // Present a frame R[k]=r0+rstep*k, I[k]=i0+istep*k and pulse start for one edge
   task automatic applyStimulus(input int r0, input int rstep, input int i0, input int istep);
      for (int k = 0; k < N; k++) begin
         stim_r[k] = r0 + rstep * k;
         stim_i[k] = i0 + istep * k;
         data_in_R[k*W +: W] = W'(stim_r[k]);
         data_in_I[k*W +: W] = W'(stim_i[k]);
      end
      start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      data_in_R = {N{18'h2AAAA}};
      data_in_I = {N{18'h15555}};
   endtask

   // mode 0: tready=1, mode 1: tready pattern 1,0,0,1, mode 2: tready=0
   task automatic idleCycles(input int n, input int mode);
      for (int c = 0; c < n; c++) begin
         if (mode == 0)      dma_tready = 1'b1;
         else if (mode == 1) dma_tready = ((c % 4) == 0) || ((c % 4) == 3);
         else                dma_tready = 1'b0;
         @(posedge clk); #2;
      end
   endtask

   task automatic clearCounters();
      beat_cnt   = 0;
      tlast_cnt  = 0;
      tlast_at   = 0;
      first_beat = 0;
      last_beat  = 0;
   endtask

   // Frame-level model: a queue of pending samples, each tagged with the edge
   // its frame was captured on; a frame occupies a slot until its last beat.
   always @(posedge clk or negedge rst_n) begin
      bit vcur;
      bit rcur;
      if (!rst_n) begin
         q.delete();
         m_ovf    = 1'b0;
         edge_cnt = 0;
      end else begin
         edge_cnt++;
         vcur = (q.size() > 0) && (q[0].cyc < edge_cnt - 1);
         rcur = ((q.size() + N - 1) / N) < 2;
         if (vcur && dma_tready) void'(q.pop_front());
         if (start) begin
            if (rcur) begin
               for (int k = 0; k < N; k++)
                  q.push_back('{r: stim_r[k], i: stim_i[k], last: (k == N - 1), cyc: edge_cnt});
            end else begin
               m_ovf = 1'b1;
            end
         end
      end
   end

   // Compare every output against the model each cycle and tally beats
   always @(negedge clk) begin
      bit ev;
      ev = (q.size() > 0) && (q[0].cyc < edge_cnt);
      checkOutput("tvalid", int'(dma_tvalid), int'(ev));
      checkOutput("ready", int'(ready), int'(((q.size() + N - 1) / N) < 2));
      checkOutput("overflow", int'(overflow), int'(m_ovf));
      checkOutput("tlast", int'(dma_tlast), int'(ev && q[0].last));
      if (ev) begin
         checkOutput("data_R", int'($signed(data_out_R)), q[0].r);
         checkOutput("data_I", int'($signed(data_out_I)), q[0].i);
      end
      if (rst_n && dma_tvalid && dma_tready) begin
         if (beat_cnt == 0) first_beat = edge_cnt + 1;
         beat_cnt++;
         last_beat = edge_cnt + 1;
         if (dma_tlast) begin
            tlast_cnt++;
            tlast_at = beat_cnt;
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation still running at 100000, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit found;

      // Reset values
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      checkOutput("rst_tvalid", int'(dma_tvalid), 0);
      checkOutput("rst_ready", int'(ready), 1);
      checkOutput("rst_overflow", int'(overflow), 0);
      checkOutput("rst_tlast", int'(dma_tlast), 0);
      checkOutput("rst_data_R", int'($signed(data_out_R)), 0);
      rst_n = 1'b1;
      @(posedge clk); #2;

      // 1: single frame, tready=1
      clearCounters();
      dma_tready = 1'b1;
      applyStimulus(1, 1, -1, -1);
      checkOutput("t1_valid_edge_t", int'(dma_tvalid), 0);
      @(posedge clk); #2;
      checkOutput("t1_valid_edge_t1", int'(dma_tvalid), 1);
      checkOutput("t1_first_R", int'($signed(data_out_R)), 1);
      checkOutput("t1_first_I", int'($signed(data_out_I)), -1);
      idleCycles(12, 0);
      checkOutput("t1_beats", beat_cnt, 8);
      checkOutput("t1_tlast_count", tlast_cnt, 1);
      checkOutput("t1_tlast_beat", tlast_at, 8);

      // 2: backpressure with tready 1,0,0,1
      clearCounters();
      dma_tready = 1'b0;
      applyStimulus(-50, 3, 7, -2);
      idleCycles(40, 1);
      checkOutput("t2_beats", beat_cnt, 8);
      checkOutput("t2_tlast_count", tlast_cnt, 1);

      // 3: back-to-back frames two cycles apart
      clearCounters();
      dma_tready = 1'b1;
      applyStimulus(100, 1, 0, 0);
      idleCycles(1, 0);
      applyStimulus(200, 1, 5, 0);
      idleCycles(25, 0);
      checkOutput("t3_beats", beat_cnt, 16);
      checkOutput("t3_tlast_count", tlast_cnt, 2);
      checkOutput("t3_tlast_beat", tlast_at, 16);
      checkOutput("t3_span", last_beat - first_beat, 15);

      // 4: overflow with tready held low
      clearCounters();
      dma_tready = 1'b0;
      applyStimulus(10, 1, -10, 0);
      checkOutput("t4_ready_one", int'(ready), 1);
      idleCycles(1, 2);
      applyStimulus(20, 1, -20, 0);
      checkOutput("t4_ready_two", int'(ready), 0);
      idleCycles(1, 2);
      checkOutput("t4_ovf_before", int'(overflow), 0);
      applyStimulus(30, 1, -30, 0);
      checkOutput("t4_ovf_after", int'(overflow), 1);
      idleCycles(30, 0);
      checkOutput("t4_beats", beat_cnt, 16);
      checkOutput("t4_tlast_count", tlast_cnt, 2);

      // 5: start coincides with final beat while both slots full
      rst_n = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b1;
      checkOutput("t5_ovf_cleared", int'(overflow), 0);
      clearCounters();
      dma_tready = 1'b0;
      applyStimulus(300, 1, -300, -1);
      applyStimulus(400, 1, -400, -1);
      checkOutput("t5_ready_full", int'(ready), 0);
      dma_tready = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 30 && !found; c++) begin
         @(posedge clk); #2;
         if (dma_tvalid && dma_tlast) found = 1'b1;
      end
      checkOutput("t5_reach_last", int'(found), 1);
      if (found) begin
         checkOutput("t5_ready_at_last", int'(ready), 0);
         applyStimulus(500, 1, 0, 0);
         checkOutput("t5_ovf", int'(overflow), 1);
         checkOutput("t5_ready_freed", int'(ready), 1);
         applyStimulus(600, 1, -600, 1);
      end
      idleCycles(30, 0);
      checkOutput("t5_beats", beat_cnt, 24);
      checkOutput("t5_tlast_count", tlast_cnt, 3);

      // 6: reset after beat 3 of a frame
      clearCounters();
      dma_tready = 1'b1;
      applyStimulus(700, 1, -700, -1);
      for (int c = 0; c < 20 && beat_cnt < 3; c++) begin
         @(posedge clk); #2;
      end
      checkOutput("t6_beats_before", beat_cnt, 3);
      rst_n = 1'b0;
      #1;
      checkOutput("t6_tvalid", int'(dma_tvalid), 0);
      checkOutput("t6_ready", int'(ready), 1);
      checkOutput("t6_overflow", int'(overflow), 0);
      checkOutput("t6_tlast", int'(dma_tlast), 0);
      checkOutput("t6_data_R", int'($signed(data_out_R)), 0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      applyStimulus(800, -1, 40, 2);
      @(posedge clk); #2;
      checkOutput("t6_new_valid", int'(dma_tvalid), 1);
      checkOutput("t6_new_R", int'($signed(data_out_R)), 800);
      checkOutput("t6_new_I", int'($signed(data_out_I)), 40);
      idleCycles(15, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
